// File: rtl/npu_sched_pkg.sv
// Shared constants and state encoding for the dense-core dispatch scheduler.
package npu_sched_pkg;

    localparam int unsigned NUM_CORES_DEF  = 8;
    localparam int unsigned TILE_OC_DEF    = 32;
    localparam int unsigned TILE_IDX_W_DEF = 3;
    localparam int unsigned OC_W           = 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DISPATCH = 2'd1,
        DRAIN    = 2'd2,
        FINISH   = 2'd3
    } sched_state_e;

endpackage

// File: rtl/core_dispatch_sched_if.sv
// Layer-control and per-core job signals between the scheduler and its environment.
interface core_dispatch_sched_if
    import npu_sched_pkg::*;
#(
    parameter int unsigned NUM_CORES  = NUM_CORES_DEF,
    parameter int unsigned TILE_IDX_W = TILE_IDX_W_DEF
);

    logic                            start;
    logic [OC_W-1:0]                 OC;
    logic [NUM_CORES-1:0]            core_done;
    logic [NUM_CORES-1:0]            core_start;
    logic [NUM_CORES*TILE_IDX_W-1:0] core_tile;
    logic [NUM_CORES-1:0]            core_busy;
    logic                            busy;
    logic                            done;
    logic                            err_spurious;

    modport master (
        output start, OC, core_done,
        input  core_start, core_tile, core_busy, busy, done, err_spurious
    );

    modport slave (
        input  start, OC, core_done,
        output core_start, core_tile, core_busy, busy, done, err_spurious
    );

endinterface

// File: rtl/prio_enc.sv
// Lowest-index priority encoder: one-hot grant of the lowest set request bit.
module prio_enc #(
    parameter int unsigned N = 8
) (
    input  logic [N-1:0] req_i,
    output logic [N-1:0] gnt_c,
    output logic         valid_c
);

    // Two's complement isolates the lowest set bit.
    always_comb begin
        gnt_c   = req_i & (~req_i + N'(1));
        valid_c = |req_i;
    end

endmodule

// File: rtl/core_dispatch_sched.sv
// Dispatches the OC tiles of a layer to free dense cores and tracks their completion.
module core_dispatch_sched
    import npu_sched_pkg::*;
#(
    parameter int unsigned NUM_CORES  = NUM_CORES_DEF,
    parameter int unsigned TILE_OC    = TILE_OC_DEF,
    parameter int unsigned TILE_IDX_W = TILE_IDX_W_DEF
) (
    input logic                  clk,
    input logic                  reset,
    core_dispatch_sched_if.slave bus
);

    localparam int unsigned CNT_W = TILE_IDX_W + 1;
    localparam int unsigned DIV_W = OC_W + 1;

    sched_state_e                    state_q, state_d;
    logic [CNT_W-1:0]                num_tiles_q, num_tiles_d;
    logic [CNT_W-1:0]                issue_q, issue_d;
    logic [CNT_W-1:0]                complete_q, complete_d;
    logic [NUM_CORES-1:0]            core_start_q, core_start_d;
    logic [NUM_CORES*TILE_IDX_W-1:0] core_tile_q, core_tile_d;
    logic [NUM_CORES-1:0]            core_busy_q, core_busy_d;
    logic                            busy_q, busy_d;
    logic                            done_q, done_d;
    logic                            err_q, err_d;

    logic [NUM_CORES-1:0]            grant_c;
    logic                            grant_valid_c;
    logic [NUM_CORES-1:0]            done_valid_c;
    logic [CNT_W-1:0]                done_cnt_c;
    logic [CNT_W-1:0]                complete_sum_c;
    logic [CNT_W-1:0]                tiles_c;

    prio_enc #(
        .N (NUM_CORES)
    ) u_prio_enc (
        .req_i   (~core_busy_q),
        .gnt_c   (grant_c),
        .valid_c (grant_valid_c)
    );

    // Tile count of the requested layer and popcount of accepted completions.
    always_comb begin
        tiles_c      = CNT_W'((DIV_W'(bus.OC) + DIV_W'(TILE_OC - 1)) / DIV_W'(TILE_OC));
        done_valid_c = bus.core_done & core_busy_q;
        done_cnt_c   = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            done_cnt_c = done_cnt_c + CNT_W'(done_valid_c[i]);
        end
        complete_sum_c = complete_q + done_cnt_c;
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d      = state_q;
        num_tiles_d  = num_tiles_q;
        issue_d      = issue_q;
        complete_d   = (complete_sum_c > num_tiles_q) ? num_tiles_q : complete_sum_c;
        core_start_d = '0;
        core_tile_d  = core_tile_q;
        core_busy_d  = core_busy_q & ~done_valid_c;
        done_d       = 1'b0;
        err_d        = err_q | (|(bus.core_done & ~core_busy_q));

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    num_tiles_d = tiles_c;
                    complete_d  = '0;
                    err_d       = 1'b0;
                    core_busy_d = '0;
                    issue_d     = '0;
                    if (tiles_c == '0) begin
                        state_d = FINISH;
                    end else begin
                        // Every core is free here, so tile 0 goes straight to core 0.
                        core_start_d                 = NUM_CORES'(1);
                        core_busy_d                  = NUM_CORES'(1);
                        core_tile_d[TILE_IDX_W-1:0]  = '0;
                        issue_d                      = CNT_W'(1);
                        state_d = (tiles_c == CNT_W'(1)) ? DRAIN : DISPATCH;
                    end
                end
            end
            DISPATCH: begin
                if (grant_valid_c && (issue_q < num_tiles_q)) begin
                    core_start_d = grant_c;
                    core_busy_d  = core_busy_d | grant_c;
                    for (int i = 0; i < NUM_CORES; i++) begin
                        if (grant_c[i]) begin
                            core_tile_d[i*TILE_IDX_W +: TILE_IDX_W] = TILE_IDX_W'(issue_q);
                        end
                    end
                    issue_d = issue_q + CNT_W'(1);
                end
                if (issue_d == num_tiles_q) begin
                    state_d = DRAIN;
                end
                if (complete_d == num_tiles_q) begin
                    state_d = FINISH;
                end
            end
            DRAIN: begin
                if (complete_d == num_tiles_q) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            num_tiles_q  <= '0;
            issue_q      <= '0;
            complete_q   <= '0;
            core_start_q <= '0;
            core_tile_q  <= '0;
            core_busy_q  <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            num_tiles_q  <= num_tiles_d;
            issue_q      <= issue_d;
            complete_q   <= complete_d;
            core_start_q <= core_start_d;
            core_tile_q  <= core_tile_d;
            core_busy_q  <= core_busy_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign bus.core_start   = core_start_q;
    assign bus.core_tile    = core_tile_q;
    assign bus.core_busy    = core_busy_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.err_spurious = err_q;

endmodule
